change_dispense_controller: RTL and testbench

- Sequences the physical coin dispenser when change is returned. It accepts a total return amount and breaks it into coins greedily, largest first.
- Issues one coin per valid/ready handshake to the dispenser mechanism.
- Reports completion, the undispensable residual, and dispenser stalls.
- Sits between the coin-return decision logic (return trigger / wait-time expiry) and the coin ejector.

---
 rtl/change_dispense_controller.sv | 150 +++++++++++++++
 tb/tb_change_dispense_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_controller.sv
// Change dispenser sequencer: breaks a return amount into coins, largest first,
// and offers them one at a time to the coin ejector over a valid/ready handshake.
module change_dispense_controller #(
  parameter int TOTAL_BITS  = 31,
  parameter int COIN0_VAL   = 100,
  parameter int COIN1_VAL   = 500,
  parameter int COIN2_VAL   = 1000,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_return_req,
  input  logic [TOTAL_BITS-1:0] i_return_amount,
  input  logic                  i_abort,
  input  logic                  i_fault_clr,
  input  logic                  i_coin_ready,
  output logic                  o_coin_valid,
  output logic [2:0]            o_coin_sel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fault,
  output logic [TOTAL_BITS-1:0] o_remaining,
  output logic [CNT_BITS-1:0]   o_coin_count
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_OFFER, S_DONE, S_FAULT} state_t;

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VAL);
  localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VAL);
  localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VAL);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

  state_t                r_state, w_nxt_state;
  logic [SW-1:0]         r_stall, w_nxt_stall;
  logic                  r_valid, w_nxt_valid;
  logic [2:0]            r_sel, w_nxt_sel;
  logic [TOTAL_BITS-1:0] r_rem, w_nxt_rem;
  logic [CNT_BITS-1:0]   r_cnt, w_nxt_cnt;
  logic                  r_busy, r_done, r_fault;
  logic [TOTAL_BITS-1:0] w_sel_val;
  logic                  w_hs;

  assign w_hs = r_valid & i_coin_ready;

  always_comb begin
    w_sel_val = '0;
    case (r_sel)
      3'b100:  w_sel_val = C2;
      3'b010:  w_sel_val = C1;
      3'b001:  w_sel_val = C0;
      default: w_sel_val = '0;
    endcase
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_stall = r_stall;
    w_nxt_valid = r_valid;
    w_nxt_sel   = r_sel;
    w_nxt_rem   = r_rem;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_return_req) begin
          w_nxt_cnt = '0;
          if (i_return_amount != '0) begin
            w_nxt_rem   = i_return_amount;
            w_nxt_state = S_SELECT;
          end else begin
            w_nxt_rem   = '0;
            w_nxt_state = S_DONE;
          end
        end
      end
      S_SELECT: begin
        w_nxt_stall = '0;
        if (i_abort) begin
          w_nxt_state = S_DONE;
        end else if (r_rem >= C0) begin
          // Greedy pick: the largest coin that still fits the remainder.
          if (r_rem >= C2)      w_nxt_sel = 3'b100;
          else if (r_rem >= C1) w_nxt_sel = 3'b010;
          else                  w_nxt_sel = 3'b001;
          w_nxt_valid = 1'b1;
          w_nxt_state = S_OFFER;
        end else begin
          w_nxt_state = S_DONE;
        end
      end
      S_OFFER: begin
        if (w_hs) begin
          w_nxt_rem   = r_rem - w_sel_val;
          if (r_cnt != '1) w_nxt_cnt = r_cnt + CNT_BITS'(1);
          w_nxt_valid = 1'b0;
          w_nxt_sel   = '0;
          w_nxt_state = i_abort ? S_DONE : S_SELECT;
        end else if (i_abort) begin
          w_nxt_valid = 1'b0;
          w_nxt_sel   = '0;
          w_nxt_state = S_DONE;
        end else if (r_stall == STALL_LAST) begin
          w_nxt_valid = 1'b0;
          w_nxt_sel   = '0;
          w_nxt_state = S_FAULT;
        end else begin
          w_nxt_stall = r_stall + SW'(1);
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      S_FAULT: if (i_fault_clr) w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_stall <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_stall <= w_nxt_stall;
      r_valid <= w_nxt_valid;
      r_sel   <= w_nxt_sel;
      r_rem   <= w_nxt_rem;
      r_cnt   <= w_nxt_cnt;
      // Status flags are registered copies of the state being entered.
      r_busy  <= (w_nxt_state == S_SELECT) || (w_nxt_state == S_OFFER);
      r_done  <= (w_nxt_state == S_DONE);
      r_fault <= (w_nxt_state == S_FAULT);
    end
  end

  assign o_coin_valid = r_valid;
  assign o_coin_sel   = r_sel;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fault      = r_fault;
  assign o_remaining  = r_rem;
  assign o_coin_count = r_cnt;

endmodule

// File: tb/tb_change_dispense_controller.sv
// Directed bench for change_dispense_controller: inputs change and outputs are
// sampled on the falling edge; expectations are hand-computed per scenario.
module tb_change_dispense_controller;
  localparam int TB = 31;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_return_req;
  logic [TB-1:0] i_return_amount;
  logic          i_abort;
  logic          i_fault_clr;
  logic          i_coin_ready;
  logic          o_coin_valid;
  logic [2:0]    o_coin_sel;
  logic          o_busy;
  logic          o_done;
  logic          o_fault;
  logic [TB-1:0] o_remaining;
  logic [CB-1:0] o_coin_count;

  int n_checks = 0;
  int n_fail   = 0;

  change_dispense_controller dut (
    .clk(clk), .reset(reset), .i_return_req(i_return_req),
    .i_return_amount(i_return_amount), .i_abort(i_abort),
    .i_fault_clr(i_fault_clr), .i_coin_ready(i_coin_ready),
    .o_coin_valid(o_coin_valid), .o_coin_sel(o_coin_sel), .o_busy(o_busy),
    .o_done(o_done), .o_fault(o_fault), .o_remaining(o_remaining),
    .o_coin_count(o_coin_count)
  );

  always #5 clk = ~clk;

  // Pulse a request for one cycle; returns in cycle 1 of the transaction.
  task automatic request(input int amt);
    i_return_amount = TB'(amt);
    i_return_req    = 1'b1;
    @(negedge clk);
    i_return_req    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_return_req = 0; i_return_amount = '0; i_abort = 0;
    i_fault_clr = 0; i_coin_ready = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_coin_valid, o_coin_sel, o_busy, o_done, o_fault} !== 7'd0 ||
        o_remaining !== '0 || o_coin_count !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b sel=%b busy=%b done=%b fault=%b rem=%0d cnt=%0d, required all zero",
               o_coin_valid, o_coin_sel, o_busy, o_done, o_fault, o_remaining, o_coin_count);
    end
  endtask

  task automatic test_1600();
    logic [2:0] exp_sel;
    i_coin_ready = 1'b1;
    request(1600);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      exp_sel = (cyc == 2) ? 3'b100 : (cyc == 4) ? 3'b010 : (cyc == 6) ? 3'b001 : 3'b000;
      n_checks++;
      if (o_busy !== (cyc <= 7) || o_done !== (cyc == 8) ||
          o_coin_valid !== (exp_sel != 0) || o_coin_sel !== exp_sel) begin
        n_fail++;
        $display("FAIL t1600_cycle%0d: busy=%b done=%b valid=%b sel=%b, required busy=%b done=%b valid=%b sel=%b",
                 cyc, o_busy, o_done, o_coin_valid, o_coin_sel, cyc <= 7, cyc == 8, exp_sel != 0, exp_sel);
      end
      @(negedge clk);
    end
    n_checks++;
    if (o_coin_count !== 8'd3 || o_remaining !== '0) begin
      n_fail++;
      $display("FAIL t1600_final: cnt=%0d rem=%0d, required cnt=3 rem=0", o_coin_count, o_remaining);
    end
  endtask

  task automatic test_750();
    logic [2:0] sels[$];
    int dones = 0;
    bit fin = 0;
    i_coin_ready = 1'b1;
    request(750);
    for (int cyc = 1; cyc < 40 && !fin; cyc++) begin
      i_return_req = 1'b0;
      if (o_coin_valid) sels.push_back(o_coin_sel);
      if (o_done) begin dones++; fin = 1; end
      // A request while busy must be dropped, not queued.
      if (cyc == 3) begin i_return_amount = TB'(5000); i_return_req = 1'b1; end
      @(negedge clk);
    end
    i_return_req = 1'b0;
    repeat (6) begin
      if (o_coin_valid || o_done || o_busy) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (sels.size() != 3 || sels[0] !== 3'b010 || sels[1] !== 3'b001 || sels[2] !== 3'b001) begin
      n_fail++;
      $display("FAIL t750_sel_seq: got %0d offers, required 010,001,001", sels.size());
    end
    n_checks++;
    if (dones != 1 || o_coin_count !== 8'd3 || o_remaining !== TB'(50)) begin
      n_fail++;
      $display("FAIL t750_final: done_events=%0d cnt=%0d rem=%0d, required 1 3 50", dones, o_coin_count, o_remaining);
    end
  endtask

  task automatic test_stall();
    int vcyc = 0;
    bit bad_sel = 0;
    i_coin_ready = 1'b0;
    request(1000);
    @(negedge clk);
    while (o_coin_valid && vcyc < 40) begin
      if (o_coin_sel !== 3'b100) bad_sel = 1;
      vcyc++;
      @(negedge clk);
    end
    n_checks++;
    if (vcyc != 16 || bad_sel) begin
      n_fail++;
      $display("FAIL stall_valid_len: valid_cycles=%0d bad_sel=%b, required 16 and 0", vcyc, bad_sel);
    end
    n_checks++;
    if (o_coin_valid !== 1'b0 || o_fault !== 1'b1 || o_remaining !== TB'(1000) || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_fault: valid=%b fault=%b rem=%0d done=%b, required 0 1 1000 0",
               o_coin_valid, o_fault, o_remaining, o_done);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_fault !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_sticky: fault=%b busy=%b, required 1 0", o_fault, o_busy);
    end
    i_fault_clr = 1'b1;
    @(negedge clk);
    i_fault_clr = 1'b0;
    n_checks++;
    if (o_fault !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clr: fault=%b done=%b busy=%b, required 0 0 0", o_fault, o_done, o_busy);
    end
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clr_nodone: done=%b, required 0", o_done);
    end
  endtask

  task automatic test_delay();
    int waits = 0, hs = 0;
    bit fin = 0, unstable = 0, fault_seen = 0;
    logic [2:0] held = 3'b000;
    i_coin_ready = 1'b0;
    request(2000);
    for (int cyc = 1; cyc < 60 && !fin; cyc++) begin
      i_coin_ready = 1'b0;
      if (o_fault) fault_seen = 1;
      if (o_done) fin = 1;
      else if (o_coin_valid) begin
        if (waits == 0) held = o_coin_sel;
        else if (o_coin_sel !== held) unstable = 1;
        if (waits == 3) begin i_coin_ready = 1'b1; hs++; waits = 0; end
        else waits++;
      end
      @(negedge clk);
    end
    i_coin_ready = 1'b0;
    n_checks++;
    if (!fin || hs != 2 || unstable || fault_seen) begin
      n_fail++;
      $display("FAIL delay_handshakes: done=%b hs=%0d unstable=%b fault=%b, required 1 2 0 0",
               fin, hs, unstable, fault_seen);
    end
    n_checks++;
    if (o_remaining !== '0 || o_coin_count !== 8'd2) begin
      n_fail++;
      $display("FAIL delay_final: rem=%0d cnt=%0d, required 0 2", o_remaining, o_coin_count);
    end
  endtask

  task automatic test_abort();
    int guard = 0;
    int extra = 0;
    i_coin_ready = 1'b1;
    request(1500);
    while (!o_coin_valid && guard < 10) begin guard++; @(negedge clk); end
    n_checks++;
    if (o_coin_sel !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_first_sel: sel=%b, required 100", o_coin_sel);
    end
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    n_checks++;
    if (o_done !== 1'b1 || o_coin_count !== 8'd1 || o_remaining !== TB'(500) || o_coin_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: done=%b cnt=%0d rem=%0d valid=%b, required 1 1 500 0",
               o_done, o_coin_count, o_remaining, o_coin_valid);
    end
    repeat (5) begin
      @(negedge clk);
      if (o_coin_valid || o_busy) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL abort_no_more_offers: active_cycles=%0d, required 0", extra);
    end
  endtask

  task automatic test_reset_offer();
    logic [2:0] sels[$];
    int guard = 0;
    bit fin = 0;
    i_coin_ready = 1'b0;
    request(1600);
    while (!o_coin_valid && guard < 10) begin guard++; @(negedge clk); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({o_coin_valid, o_coin_sel, o_busy, o_done, o_fault} !== 7'd0 ||
        o_remaining !== '0 || o_coin_count !== '0) begin
      n_fail++;
      $display("FAIL reset_in_offer: valid=%b sel=%b busy=%b done=%b fault=%b rem=%0d cnt=%0d, required all zero",
               o_coin_valid, o_coin_sel, o_busy, o_done, o_fault, o_remaining, o_coin_count);
    end
    i_coin_ready = 1'b1;
    request(100);
    for (int cyc = 1; cyc < 20 && !fin; cyc++) begin
      if (o_coin_valid) sels.push_back(o_coin_sel);
      if (o_done) fin = 1;
      @(negedge clk);
    end
    n_checks++;
    if (!fin || sels.size() != 1 || sels[0] !== 3'b001 || o_coin_count !== 8'd1 || o_remaining !== '0) begin
      n_fail++;
      $display("FAIL post_reset_100: done=%b offers=%0d cnt=%0d rem=%0d, required 1 1(001) 1 0",
               fin, sels.size(), o_coin_count, o_remaining);
    end
  endtask

  task automatic test_zero_and_small();
    i_abort = 1'b1;
    i_fault_clr = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    i_fault_clr = 1'b0;
    request(0);
    n_checks++;
    if (o_done !== 1'b1 || o_remaining !== '0 || o_busy !== 1'b0 || o_coin_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_amount: done=%b rem=%0d busy=%b valid=%b, required 1 0 0 0",
               o_done, o_remaining, o_busy, o_coin_valid);
    end
    @(negedge clk);
    // Below the smallest coin: one SELECT cycle, then DONE with the residual kept.
    request(99);
    n_checks++;
    if (o_busy !== 1'b1 || o_remaining !== TB'(99)) begin
      n_fail++;
      $display("FAIL small_select: busy=%b rem=%0d, required 1 99", o_busy, o_remaining);
    end
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b1 || o_coin_valid !== 1'b0 || o_remaining !== TB'(99) || o_coin_count !== '0) begin
      n_fail++;
      $display("FAIL small_done: done=%b valid=%b rem=%0d cnt=%0d, required 1 0 99 0",
               o_done, o_coin_valid, o_remaining, o_coin_count);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_1600();
    test_750();
    test_stall();
    test_delay();
    test_abort();
    test_reset_offer();
    test_zero_and_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
